fetch_unit: RTL and testbench

- Instruction-fetch sequencer directly downstream of the PC mux.
- Consumes the registered PC, drives the PC mux load/select controls, issues a word read to instruction memory and latches the returned instruction into IR.
- Presents IR to decode with a valid/ready handshake.
- Owns all PC mux control; branch/jump redirects from execute pass through it.

---
 rtl/lc3b_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lc3b_pkg.sv
// Shared PC-mux select encoding and fetch sequencer state type.
package lc3b_pkg;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_SEL_INC   = 2'd0;
    localparam pc_sel_t PC_SEL_BUS   = 2'd1;
    localparam pc_sel_t PC_SEL_ADDER = 2'd2;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Only BUS and ADDER are meaningful redirect targets; anything else falls back to INC.
    function automatic pc_sel_t redirect_src(input pc_sel_t sel);
        return ((sel == PC_SEL_BUS) || (sel == PC_SEL_ADDER)) ? sel : PC_SEL_INC;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives the PC mux, reads instruction memory, hands IR to decode.
// Optional misaligned-fetch trap is compiled in with FETCH_ALIGN_CHECK_EN.
//
// state | meaning
// ISSUE | load PC+2, capture fetch address, start read
// WAIT  | read outstanding, waiting for mem_ready
// VALID | ir holds an instruction, waiting for decode
// FAULT | misaligned PC trapped, idle until redirect
module fetch_unit
    import lc3b_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    output logic              ld_pc,
    output logic [1:0]        pc_sel,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [1:0]        redirect_sel,
    output logic              fetch_fault
);

    fetch_state_t      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              fault_q, fault_d;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d    = fault_q;
`endif
        ld_pc      = 1'b0;
        pc_sel     = PC_SEL_INC;

        if (redirect) begin
            // Abandons any in-flight read; a concurrent ir_ready handshake is implicitly consumed.
            ld_pc      = 1'b1;
            pc_sel     = redirect_src(redirect_sel);
            state_d    = ISSUE;
            mem_req_d  = 1'b0;
            ir_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ISSUE: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc[0]) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else
`endif
                    begin
                        ld_pc      = 1'b1;
                        mem_addr_d = {pc[ADDR_W-1:1], 1'b0};
                        ir_pc_d    = pc;
                        mem_req_d  = 1'b1;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        ir_d       = mem_data;
                        ir_valid_d = 1'b1;
                        mem_req_d  = 1'b0;
                        state_d    = VALID;
                    end
                end
                VALID: begin
                    if (ir_ready) begin
                        ir_valid_d = 1'b0;
                        state_d    = ISSUE;
                    end
                end
                FAULT: begin
`ifndef FETCH_ALIGN_CHECK_EN
                    state_d = ISSUE;
`endif
                end
                default: state_d = ISSUE;
            endcase
        end

        // Keep the PC mux quiet while reset is held, even though state sits at ISSUE.
        if (!rst_n) begin
            ld_pc  = 1'b0;
            pc_sel = PC_SEL_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ISSUE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC mux in the loop.
module tb_fetch_unit;
    import lc3b_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        ld_pc;
    logic [1:0]  pc_sel;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [1:0]  redirect_sel;
    logic        fetch_fault;
    logic [15:0] tgt;

    int n_tests;
    int n_fail;

    fetch_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .ld_pc(ld_pc), .pc_sel(pc_sel),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_sel(redirect_sel), .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register + mux; BUS and ADDER both present the bench-driven target value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 16'h0000;
        else if (ld_pc) begin
            case (pc_sel)
                PC_SEL_INC:   pc <= pc + 16'd2;
                PC_SEL_BUS:   pc <= tgt;
                PC_SEL_ADDER: pc <= tgt;
                default:      pc <= 16'hXXXX;
            endcase
        end
    end

    typedef struct {
        logic        redir;
        logic [1:0]  rsel;
        logic [15:0] tgt;
        logic        mrdy;
        logic [15:0] mdata;
        logic        irdy;
        logic        e_ld;
        logic [1:0]  e_sel;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_irv;
        logic [15:0] e_ir;
        logic [15:0] e_irpc;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic redir, logic [1:0] rsel, logic [15:0] t, logic mrdy,
                                logic [15:0] mdata, logic irdy, logic e_ld, logic [1:0] e_sel,
                                logic e_req, logic [15:0] e_addr, logic e_irv, logic [15:0] e_ir,
                                logic [15:0] e_irpc, logic [15:0] e_pc);
        vec_t v;
        v.redir = redir; v.rsel = rsel; v.tgt = t; v.mrdy = mrdy; v.mdata = mdata; v.irdy = irdy;
        v.e_ld = e_ld; v.e_sel = e_sel; v.e_req = e_req; v.e_addr = e_addr; v.e_irv = e_irv;
        v.e_ir = e_ir; v.e_irpc = e_irpc; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; redirect = 1'b0; redirect_sel = 2'd0; tgt = 16'h0;
        mem_ready = 1'b0; mem_data = 16'h0; ir_ready = 1'b0;

        //        redir sel tgt      mrdy mdata    irdy | ld sel req addr     irv ir       irpc     pc
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1234, 0,  0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0002));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 0, 16'h1234, 16'h0000, 16'h0002));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hA002, 0,  0, 0, 1, 16'h0002, 0, 16'h1234, 16'h0002, 16'h0004));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 16'h0002, 1, 16'hA002, 16'h0002, 16'h0004));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 0, 16'h0002, 0, 16'hA002, 16'h0002, 16'h0004));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hA004, 0,  0, 0, 1, 16'h0004, 0, 16'hA002, 16'h0004, 16'h0006));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hFFFF, 0,  0, 0, 0, 16'h0004, 1, 16'hA004, 16'h0004, 16'h0006));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 16'h0004, 1, 16'hA004, 16'h0004, 16'h0006));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 0, 16'h0004, 0, 16'hA004, 16'h0004, 16'h0006));
        vecs.push_back(mk(1, 2, 16'h0042, 1, 16'hA006, 0,  1, 2, 1, 16'h0006, 0, 16'hA004, 16'h0006, 16'h0008));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 0, 16'h0006, 0, 16'hA004, 16'h0006, 16'h0042));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hB042, 0,  0, 0, 1, 16'h0042, 0, 16'hA004, 16'h0042, 16'h0044));
        vecs.push_back(mk(1, 1, 16'h0068, 0, 16'h0000, 1,  1, 1, 0, 16'h0042, 1, 16'hB042, 16'h0042, 16'h0044));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 0, 16'h0042, 0, 16'hB042, 16'h0042, 16'h0068));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hC068, 0,  0, 0, 1, 16'h0068, 0, 16'hB042, 16'h0068, 16'h006A));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 16'h0068, 1, 16'hC068, 16'h0068, 16'h006A));
        vecs.push_back(mk(1, 3, 16'h0000, 0, 16'h0000, 0,  1, 0, 0, 16'h0068, 0, 16'hC068, 16'h0068, 16'h006A));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 0, 16'h0068, 0, 16'hC068, 16'h0068, 16'h006C));
        vecs.push_back(mk(1, 1, 16'h0010, 0, 16'h0000, 0,  1, 1, 1, 16'h006C, 0, 16'hC068, 16'h006C, 16'h006E));
        vecs.push_back(mk(1, 1, 16'h0003, 0, 16'h0000, 0,  1, 1, 0, 16'h006C, 0, 16'hC068, 16'h006C, 16'h0010));

        repeat (2) @(posedge clk);
        #1;
        chk("reset", {ld_pc, pc_sel, mem_req, mem_addr, ir_valid, ir, ir_pc, pc, fetch_fault}, 70'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            redirect = vecs[i].redir; redirect_sel = vecs[i].rsel; tgt = vecs[i].tgt;
            mem_ready = vecs[i].mrdy; mem_data = vecs[i].mdata; ir_ready = vecs[i].irdy;
            #1;
            chk($sformatf("vec%0d", i),
                {ld_pc, pc_sel, mem_req, mem_addr, ir_valid, ir, ir_pc, pc, fetch_fault},
                {vecs[i].e_ld, vecs[i].e_sel, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_irv,
                 vecs[i].e_ir, vecs[i].e_irpc, vecs[i].e_pc, 1'b0});
        end

        @(negedge clk);
        redirect = 1'b0; redirect_sel = 2'd0; mem_ready = 1'b0; ir_ready = 1'b0;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_issue", {ld_pc, mem_req, fetch_fault, pc}, {1'b0, 1'b0, 1'b0, 16'h0003});
        @(negedge clk); #1;
        chk("fault_set", {ld_pc, mem_req, fetch_fault, pc}, {1'b0, 1'b0, 1'b1, 16'h0003});
        @(negedge clk); #1;
        chk("fault_hold", {ld_pc, mem_req, fetch_fault, pc}, {1'b0, 1'b0, 1'b1, 16'h0003});
        @(negedge clk);
        redirect = 1'b1; redirect_sel = PC_SEL_BUS; tgt = 16'h0004;
        #1;
        chk("fault_redirect", {ld_pc, pc_sel, fetch_fault}, {1'b1, PC_SEL_BUS, 1'b1});
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("fault_clear", {ld_pc, mem_req, fetch_fault, pc}, {1'b1, 1'b0, 1'b0, 16'h0004});
        @(negedge clk); #1;
        chk("aligned_fetch", {mem_req, mem_addr, fetch_fault}, {1'b1, 16'h0004, 1'b0});
`else
        chk("odd_pc_issue", {ld_pc, mem_req, fetch_fault, pc}, {1'b1, 1'b0, 1'b0, 16'h0003});
        @(negedge clk); #1;
        chk("odd_pc_fetch", {mem_req, mem_addr, ir_pc, fetch_fault}, {1'b1, 16'h0002, 16'h0003, 1'b0});
`endif

        // Reset asserted mid-read while data is being returned.
        @(negedge clk);
        mem_ready = 1'b1; mem_data = 16'hDEAD;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async", {ld_pc, mem_req, ir_valid, mem_addr}, 70'd0);
        @(posedge clk); #1;
        chk("rst_no_latch", {ir, ir_valid, mem_req, fetch_fault}, 70'd0);
        @(negedge clk);
        mem_ready = 1'b0; mem_data = 16'h0;
        rst_n = 1'b1;
        #1;
        chk("rst_release", {ld_pc, pc_sel, pc, ir, ir_valid}, {1'b1, PC_SEL_INC, 16'h0000, 16'h0000, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
